tls_lamp_monitor: RTL and testbench

Receiving end of the two-road traffic-light interface. It samples the one-hot lamp codes driven by the light controller, checks them for illegal codes, conflicting greens, illegal colour sequences and dwell-time violations, and forwards them to the lamp drivers. On the first fault it latches a diagnostic code and forces both roads to red until reset. It sits between the light controller and the physical lamp drivers.

---
 rtl/tls_lamp_monitor.sv | 155 +++++++++++++++
 tb/tb_tls_lamp_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tls_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tls_lamp_monitor
// Description : Checks controller lamp codes for two roads and forwards them to
//               the lamp drivers. On the first fault it forces both roads to red.
// Revision    : 1.0 - initial release
// ============================================================================
module tls_lamp_monitor #(
    parameter int DW        = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int MIN_YEL   = 1,
    parameter int MAX_YEL   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] la,
    input  logic [2:0] lb,
    output logic [2:0] la_out,
    output logic [2:0] lb_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_road,
    output logic [7:0] cycles
);

    localparam logic [2:0]    c_G      = 3'b100;
    localparam logic [2:0]    c_Y      = 3'b010;
    localparam logic [2:0]    c_R      = 3'b001;
    localparam logic [DW-1:0] c_DW_MAX = '1;

    typedef struct packed {
        logic          ill;
        logic          seq;
        logic          tim;
        logic          part;
        logic [DW-1:0] dwell;
    } road_t;

    // Per-road check of one sample against the previously sampled code.
    function automatic road_t eval_road(input logic [2:0]    code,
                                        input logic [2:0]    prev,
                                        input logic [DW-1:0] dwell,
                                        input logic          part);
        road_t res;
        res.ill   = !(code == c_G || code == c_Y || code == c_R);
        res.seq   = 1'b0;
        res.tim   = 1'b0;
        res.part  = part;
        res.dwell = dwell;
        if (code == prev) begin
            res.dwell = (dwell == c_DW_MAX) ? dwell : dwell + 1'b1;
            if (code == c_G && res.dwell > DW'(MAX_GREEN)) res.tim = 1'b1;
            if (code == c_Y && res.dwell > DW'(MAX_YEL))   res.tim = 1'b1;
        end else begin
            res.seq = !((prev == c_G && code == c_Y) ||
                        (prev == c_Y && code == c_R) ||
                        (prev == c_R && code == c_G));
            if (!part && prev == c_G && dwell < DW'(MIN_GREEN)) res.tim = 1'b1;
            if (!part && prev == c_Y && dwell < DW'(MIN_YEL))   res.tim = 1'b1;
            res.part  = 1'b0;
            res.dwell = DW'(1);
        end
        return res;
    endfunction

    logic          r_armed;
    logic [2:0]    r_prev_a, r_prev_b;
    logic [DW-1:0] r_dwell_a, r_dwell_b;
    logic          r_part_a, r_part_b;

    road_t      w_a, w_b;
    logic       w_conflict;
    logic [2:0] w_det_code;
    logic       w_det_road;
    logic       w_new_fault;
    logic       w_kill;
    logic       w_cycle_inc;

    always_comb begin
        w_a        = eval_road(la, r_prev_a, r_dwell_a, r_part_a);
        w_b        = eval_road(lb, r_prev_b, r_dwell_b, r_part_b);
        w_conflict = (la != c_R) && (lb != c_R);
        w_det_code = 3'd0;
        w_det_road = 1'b0;
        // Lowest code wins; within a code, road A wins.
        if (w_a.ill) begin
            w_det_code = 3'd1;
        end else if (w_b.ill) begin
            w_det_code = 3'd1;
            w_det_road = 1'b1;
        end else if (w_conflict) begin
            w_det_code = 3'd2;
        end else if (r_armed) begin
            if (w_a.seq) begin
                w_det_code = 3'd3;
            end else if (w_b.seq) begin
                w_det_code = 3'd3;
                w_det_road = 1'b1;
            end else if (w_a.tim) begin
                w_det_code = 3'd4;
            end else if (w_b.tim) begin
                w_det_code = 3'd4;
                w_det_road = 1'b1;
            end
        end
        w_new_fault = !fault && (w_det_code != 3'd0);
        w_kill      = fault || w_new_fault;
        w_cycle_inc = r_armed && (r_prev_a == c_R) && (la == c_G) && !w_kill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            la_out     <= c_R;
            lb_out     <= c_R;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_road <= 1'b0;
            cycles     <= 8'd0;
            r_armed    <= 1'b0;
            r_prev_a   <= c_R;
            r_prev_b   <= c_R;
            r_dwell_a  <= '0;
            r_dwell_b  <= '0;
            r_part_a   <= 1'b1;
            r_part_b   <= 1'b1;
        end else begin
            la_out   <= w_kill ? c_R : la;
            lb_out   <= w_kill ? c_R : lb;
            r_prev_a <= la;
            r_prev_b <= lb;
            r_armed  <= 1'b1;
            if (w_new_fault) begin
                fault      <= 1'b1;
                fault_code <= w_det_code;
                fault_road <= w_det_road;
            end
            if (w_cycle_inc) begin
                cycles <= cycles + 8'd1;
            end
            if (r_armed) begin
                r_dwell_a <= w_a.dwell;
                r_dwell_b <= w_b.dwell;
                r_part_a  <= w_a.part;
                r_part_b  <= w_b.part;
            end else begin
                // First sample after reset opens partial segments on both roads.
                r_dwell_a <= DW'(1);
                r_dwell_b <= DW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tls_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_tls_lamp_monitor
// Description : Directed and randomized checks of tls_lamp_monitor against a
//               run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tls_lamp_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] la  = 3'b001;
    logic [2:0] lb  = 3'b001;
    logic [2:0] la_out, lb_out;
    logic       fault;
    logic [2:0] fault_code;
    logic       fault_road;
    logic [7:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    tls_lamp_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .la        (la),
        .lb        (lb),
        .la_out    (la_out),
        .lb_out    (lb_out),
        .fault     (fault),
        .fault_code(fault_code),
        .fault_road(fault_road),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    // Colour index: 0 red, 1 green, 2 yellow; legal order is index+1 mod 3.
    int min_len[3] = '{0, 4, 1};
    int max_len[3] = '{0, 16, 4};

    int         m_armed;
    logic [2:0] m_prev[2];
    int         m_run[2];
    int         m_part[2];
    int         m_fault, m_code, m_road, m_cycles;
    logic [2:0] m_out[2];

    function automatic int col(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b100:  return 1;
            3'b010:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed  = 0;
        m_fault  = 0;
        m_code   = 0;
        m_road   = 0;
        m_cycles = 0;
        for (int r = 0; r < 2; r++) begin
            m_prev[r] = 3'b001;
            m_run[r]  = 0;
            m_part[r] = 1;
            m_out[r]  = 3'b001;
        end
    endtask

    task automatic model_step(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] v[2];
        int best;
        int inc;
        v[0] = a;
        v[1] = b;
        best = 99;   // encoded as code*2 + road
        inc  = 0;
        for (int r = 0; r < 2; r++)
            if (col(v[r]) < 0 && 2 + r < best) best = 2 + r;
        if (a != 3'b001 && b != 3'b001 && 4 < best) best = 4;
        if (m_armed != 0) begin
            if (col(m_prev[0]) == 0 && col(a) == 1) inc = 1;
            for (int r = 0; r < 2; r++) begin
                int pc, nc;
                pc = col(m_prev[r]);
                nc = col(v[r]);
                if (v[r] == m_prev[r]) begin
                    if (m_run[r] < 255) m_run[r]++;
                    if (pc > 0 && m_run[r] > max_len[pc] && 8 + r < best) best = 8 + r;
                end else begin
                    if ((pc < 0 || nc < 0 || nc != (pc + 1) % 3) && 6 + r < best) best = 6 + r;
                    if (m_part[r] == 0 && pc >= 0 && m_run[r] < min_len[pc] && 8 + r < best)
                        best = 8 + r;
                    m_run[r]  = 1;
                    m_part[r] = 0;
                end
            end
        end else begin
            m_run[0] = 1;
            m_run[1] = 1;
            m_armed  = 1;
        end
        m_prev[0] = a;
        m_prev[1] = b;
        if (m_fault == 0 && best < 99) begin
            m_fault = 1;
            m_code  = best / 2;
            m_road  = best % 2;
        end
        if (inc != 0 && m_fault == 0) m_cycles = (m_cycles + 1) % 256;
        m_out[0] = (m_fault != 0) ? 3'b001 : a;
        m_out[1] = (m_fault != 0) ? 3'b001 : b;
    endtask

    task automatic check_all();
        chk("la_out",     32'(la_out),     32'(m_out[0]));
        chk("lb_out",     32'(lb_out),     32'(m_out[1]));
        chk("fault",      32'(fault),      32'(m_fault));
        chk("fault_code", 32'(fault_code), 32'(m_code));
        chk("fault_road", 32'(fault_road), 32'(m_road));
        chk("cycles",     32'(cycles),     32'(m_cycles));
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b);
        rst = 1'b0;
        la  = a;
        lb  = b;
        @(posedge clk);
        model_step(a, b);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
        repeat (n) step(a, b);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            model_reset();
            #1;
            check_all();
        end
    endtask

    // Occasionally replaces one road's code with an arbitrary 3-bit value.
    task automatic emit(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] x, y;
        x = a;
        y = b;
        if ($urandom % 60 == 0) begin
            if ($urandom % 2 == 0) x = 3'($urandom_range(0, 7));
            else                   y = 3'($urandom_range(0, 7));
        end
        step(x, y);
    endtask

    task automatic rand_episode(input int phases);
        int gl, yl, rr;
        logic [2:0] g, yv;
        do_reset(1);
        emit(3'b001, 3'b001);
        for (int p = 0; p < phases; p++) begin
            gl = ($urandom % 6 == 0) ? $urandom_range(1, 20) : $urandom_range(4, 16);
            yl = ($urandom % 6 == 0) ? $urandom_range(0, 6)  : $urandom_range(1, 4);
            rr = ($urandom % 5 == 0) ? $urandom_range(1, 3)  : 0;
            for (int k = 0; k < gl; k++) begin
                g = 3'b100;
                if (p % 2 == 0) emit(g, 3'b001);
                else            emit(3'b001, g);
            end
            for (int k = 0; k < yl; k++) begin
                yv = 3'b010;
                if (p % 2 == 0) emit(yv, 3'b001);
                else            emit(3'b001, yv);
            end
            for (int k = 0; k < rr; k++) emit(3'b001, 3'b001);
        end
    endtask

    initial begin
        model_reset();

        // Reset, then A red / B green forwarded with one cycle of latency.
        do_reset(2);
        hold(3'b001, 3'b100, 5);
        chk("t1_fault", 32'(fault), 32'd0);
        chk("t1_lb_out", 32'(lb_out), 32'b100);

        // Two legal signal cycles.
        hold(3'b001, 3'b100, 5);
        hold(3'b001, 3'b010, 2);
        hold(3'b100, 3'b001, 5);
        chk("t2_cycles1", 32'(cycles), 32'd1);
        hold(3'b010, 3'b001, 2);
        hold(3'b001, 3'b100, 5);
        hold(3'b001, 3'b010, 2);
        hold(3'b100, 3'b001, 5);
        hold(3'b010, 3'b001, 2);
        hold(3'b001, 3'b100, 1);
        chk("t2_cycles2", 32'(cycles), 32'd2);
        chk("t2_fault", 32'(fault), 32'd0);

        // Conflicting greens, sticky red.
        step(3'b100, 3'b010);
        chk("t3_code", 32'(fault_code), 32'd2);
        chk("t3_road", 32'(fault_road), 32'd0);
        hold(3'b001, 3'b100, 3);
        chk("t3_lb_out", 32'(lb_out), 32'b001);
        chk("t3_cycles", 32'(cycles), 32'd2);

        // Reset mid-fault; partial green segment is exempt from minimum dwell.
        do_reset(1);
        hold(3'b100, 3'b001, 2);
        step(3'b010, 3'b001);
        chk("t6_fault", 32'(fault), 32'd0);
        chk("t6_la_out", 32'(la_out), 32'b010);

        // Illegal code beats a simultaneous sequence fault.
        do_reset(1);
        hold(3'b100, 3'b001, 3);
        step(3'b001, 3'b011);
        chk("t4_code", 32'(fault_code), 32'd1);
        chk("t4_road", 32'(fault_road), 32'd1);

        // Green held past its maximum.
        do_reset(1);
        step(3'b001, 3'b010);
        step(3'b001, 3'b001);
        hold(3'b001, 3'b100, 16);
        chk("t5_nofault16", 32'(fault), 32'd0);
        step(3'b001, 3'b100);
        chk("t5_max_code", 32'(fault_code), 32'd4);
        chk("t5_max_road", 32'(fault_road), 32'd1);

        // Green left before its minimum.
        do_reset(1);
        step(3'b001, 3'b001);
        hold(3'b001, 3'b100, 3);
        step(3'b001, 3'b010);
        chk("t5_min_code", 32'(fault_code), 32'd4);
        chk("t5_min_road", 32'(fault_road), 32'd1);

        for (int e = 0; e < 12; e++) rand_episode(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
